// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
//   Hazard and control-flow recovery controller for a pipeline with an
//   IF / ID / EX1 / EX2 structure. Loads in EX1 cost two bubbles and loads
//   in EX2 cost one bubble. A branch mispredict or a jr resolved in EX2
//   redirects the PC and flushes the younger buffers. One RECOVER cycle
//   follows each redirect.
//
// Optional feature:
//   HAZARD_STATS_EN - when defined, stall_cycles and mispredicts are live
//                     32-bit wrapping counters. Otherwise both are tied to 0
//                     and no counter flops exist.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   ID_rs1_ind, ID_rs2_ind        ID source register indices
//   ID_uses_rs1, ID_uses_rs2      ID instruction reads rs1 / rs2
//   EX1_rd_ind, EX2_rd_ind        destination indices in EX1 / EX2
//   EX1_memread, EX2_memread      load present in EX1 / EX2
//   EX2_is_beq/_is_bne/_is_jr     control-flow class of the EX2 instruction
//   EX2_taken, EX2_predicted      resolved outcome and carried prediction
//   EX2_PFC_to_IF                 correct next fetch address
//   PC_stall, IFID_stall          hold PC / IF-ID buffer
//   IFID_FLUSH, IDEX1_FLUSH,
//   EX1EX2_FLUSH                  zero the buffer on the next edge
//   PC_redirect, PC_target        load PC from PC_target (target 0 otherwise)
//   stall_cycles, mispredicts     statistics counters
module pipeline_hazard_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  ID_rs1_ind,
    input  logic [4:0]  ID_rs2_ind,
    input  logic        ID_uses_rs1,
    input  logic        ID_uses_rs2,
    input  logic [4:0]  EX1_rd_ind,
    input  logic [4:0]  EX2_rd_ind,
    input  logic        EX1_memread,
    input  logic        EX2_memread,
    input  logic        EX2_is_beq,
    input  logic        EX2_is_bne,
    input  logic        EX2_is_jr,
    input  logic        EX2_taken,
    input  logic        EX2_predicted,
    input  logic [31:0] EX2_PFC_to_IF,
    output logic        PC_stall,
    output logic        IFID_stall,
    output logic        IFID_FLUSH,
    output logic        IDEX1_FLUSH,
    output logic        EX1EX2_FLUSH,
    output logic        PC_redirect,
    output logic [31:0] PC_target,
    output logic [31:0] stall_cycles,
    output logic [31:0] mispredicts
);

    localparam logic [1:0] RUN     = 2'd0;
    localparam logic [1:0] STALL   = 2'd1;
    localparam logic [1:0] RECOVER = 2'd2;

    logic [1:0] state_q, state_d;
    logic [1:0] stall_cnt_q, stall_cnt_d;

    logic hz_ex1, hz_ex2, mispredict;

    always_comb begin
        hz_ex1 = EX1_memread && (EX1_rd_ind != 5'd0) &&
                 ((ID_uses_rs1 && (ID_rs1_ind == EX1_rd_ind)) ||
                  (ID_uses_rs2 && (ID_rs2_ind == EX1_rd_ind)));
        hz_ex2 = EX2_memread && (EX2_rd_ind != 5'd0) &&
                 ((ID_uses_rs1 && (ID_rs1_ind == EX2_rd_ind)) ||
                  (ID_uses_rs2 && (ID_rs2_ind == EX2_rd_ind)));
        mispredict = ((EX2_is_beq || EX2_is_bne) && (EX2_taken != EX2_predicted)) ||
                     EX2_is_jr;
    end

    always_comb begin
        state_d      = state_q;
        stall_cnt_d  = stall_cnt_q;
        PC_stall     = 1'b0;
        IFID_stall   = 1'b0;
        IFID_FLUSH   = 1'b0;
        IDEX1_FLUSH  = 1'b0;
        EX1EX2_FLUSH = 1'b0;
        PC_redirect  = 1'b0;
        PC_target    = 32'd0;

        case (state_q)
            RUN: begin
                if (mispredict) begin
                    PC_redirect  = 1'b1;
                    PC_target    = EX2_PFC_to_IF;
                    IFID_FLUSH   = 1'b1;
                    IDEX1_FLUSH  = 1'b1;
                    EX1EX2_FLUSH = 1'b1;
                    state_d      = RECOVER;
                end else if (hz_ex1) begin
                    PC_stall    = 1'b1;
                    IFID_stall  = 1'b1;
                    IDEX1_FLUSH = 1'b1;
                    stall_cnt_d = 2'd1;
                    state_d     = STALL;
                end else if (hz_ex2) begin
                    // Single bubble; the load leaves EX2 next cycle.
                    PC_stall    = 1'b1;
                    IFID_stall  = 1'b1;
                    IDEX1_FLUSH = 1'b1;
                end
            end
            STALL: begin
                if (mispredict) begin
                    PC_redirect  = 1'b1;
                    PC_target    = EX2_PFC_to_IF;
                    IFID_FLUSH   = 1'b1;
                    IDEX1_FLUSH  = 1'b1;
                    EX1EX2_FLUSH = 1'b1;
                    stall_cnt_d  = 2'd0;
                    state_d      = RECOVER;
                end else if (stall_cnt_q != 2'd0) begin
                    PC_stall    = 1'b1;
                    IFID_stall  = 1'b1;
                    IDEX1_FLUSH = 1'b1;
                    stall_cnt_d = stall_cnt_q - 2'd1;
                    // Leave as soon as the last bubble is issued.
                    if (stall_cnt_q == 2'd1) begin
                        state_d = RUN;
                    end
                end else begin
                    state_d = RUN;
                end
            end
            RECOVER: begin
                // Pipeline holds only bubbles: ignore all hazard inputs.
                state_d = RUN;
            end
            default: begin
                state_d     = RUN;
                stall_cnt_d = 2'd0;
            end
        endcase

        if (rst) begin
            PC_stall     = 1'b0;
            IFID_stall   = 1'b0;
            IFID_FLUSH   = 1'b0;
            IDEX1_FLUSH  = 1'b0;
            EX1EX2_FLUSH = 1'b0;
            PC_redirect  = 1'b0;
            PC_target    = 32'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RUN;
            stall_cnt_q <= 2'd0;
        end else begin
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

`ifdef HAZARD_STATS_EN
    logic [31:0] stall_cycles_q, mispredicts_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles_q <= 32'd0;
            mispredicts_q  <= 32'd0;
        end else begin
            if (PC_stall) begin
                stall_cycles_q <= stall_cycles_q + 32'd1;
            end
            if (PC_redirect) begin
                mispredicts_q <= mispredicts_q + 32'd1;
            end
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign mispredicts  = mispredicts_q;
`else
    assign stall_cycles = 32'd0;
    assign mispredicts  = 32'd0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Testbench for pipeline_hazard_ctrl. Each cycle's expected control vector is
// queued when the stimulus is driven. A monitor pops the entry at the falling
// edge and compares it with the DUT outputs. Statistics counters are checked
// inline by the scenario tasks.
module tb_pipeline_hazard_ctrl;

`ifdef HAZARD_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    // {PC_stall, IFID_stall, IFID_FLUSH, IDEX1_FLUSH, EX1EX2_FLUSH, PC_redirect, PC_target}
    localparam logic [37:0] IDLE   = 38'd0;
    localparam logic [37:0] BUBBLE = {6'b110100, 32'd0};

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  ID_rs1_ind, ID_rs2_ind, EX1_rd_ind, EX2_rd_ind;
    logic        ID_uses_rs1, ID_uses_rs2, EX1_memread, EX2_memread;
    logic        EX2_is_beq, EX2_is_bne, EX2_is_jr, EX2_taken, EX2_predicted;
    logic [31:0] EX2_PFC_to_IF;
    logic        PC_stall, IFID_stall, IFID_FLUSH, IDEX1_FLUSH, EX1EX2_FLUSH, PC_redirect;
    logic [31:0] PC_target, stall_cycles, mispredicts;

    int total = 0;
    int bad   = 0;
    int unsigned exp_stalls = 0;
    int unsigned exp_mis    = 0;

    logic [37:0] exp_q[$];
    string       name_q[$];

    pipeline_hazard_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .ID_rs1_ind    (ID_rs1_ind),
        .ID_rs2_ind    (ID_rs2_ind),
        .ID_uses_rs1   (ID_uses_rs1),
        .ID_uses_rs2   (ID_uses_rs2),
        .EX1_rd_ind    (EX1_rd_ind),
        .EX2_rd_ind    (EX2_rd_ind),
        .EX1_memread   (EX1_memread),
        .EX2_memread   (EX2_memread),
        .EX2_is_beq    (EX2_is_beq),
        .EX2_is_bne    (EX2_is_bne),
        .EX2_is_jr     (EX2_is_jr),
        .EX2_taken     (EX2_taken),
        .EX2_predicted (EX2_predicted),
        .EX2_PFC_to_IF (EX2_PFC_to_IF),
        .PC_stall      (PC_stall),
        .IFID_stall    (IFID_stall),
        .IFID_FLUSH    (IFID_FLUSH),
        .IDEX1_FLUSH   (IDEX1_FLUSH),
        .EX1EX2_FLUSH  (EX1EX2_FLUSH),
        .PC_redirect   (PC_redirect),
        .PC_target     (PC_target),
        .stall_cycles  (stall_cycles),
        .mispredicts   (mispredicts)
    );

    always #5 clk = ~clk;

    // Scoreboard monitor: outputs are combinational, sampled mid-cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [37:0] got, exp;
            string       nm;
            got = {PC_stall, IFID_stall, IFID_FLUSH, IDEX1_FLUSH, EX1EX2_FLUSH,
                   PC_redirect, PC_target};
            exp = exp_q.pop_front();
            nm  = name_q.pop_front();
            total++;
            if (got !== exp) begin
                bad++;
                $display("FAIL %s: got=%h expected=%h", nm, got, exp);
            end
        end
    end

    function automatic logic [37:0] redir(input logic [31:0] t);
        return {6'b001111, t};
    endfunction

    task automatic clear_in();
        ID_rs1_ind = 5'd0; ID_rs2_ind = 5'd0; ID_uses_rs1 = 1'b0; ID_uses_rs2 = 1'b0;
        EX1_rd_ind = 5'd0; EX2_rd_ind = 5'd0; EX1_memread = 1'b0; EX2_memread = 1'b0;
        EX2_is_beq = 1'b0; EX2_is_bne = 1'b0; EX2_is_jr = 1'b0;
        EX2_taken = 1'b0; EX2_predicted = 1'b0; EX2_PFC_to_IF = 32'd0;
    endtask

    // Queue the expectation for the current cycle, then advance one clock.
    task automatic step(input logic [37:0] exp, input string nm);
        exp_q.push_back(exp);
        name_q.push_back(nm);
        if (rst) begin
            exp_stalls = 0;
            exp_mis    = 0;
        end else begin
            if (exp[37]) exp_stalls++;
            if (exp[32]) exp_mis++;
        end
        @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic ex1_load_inputs(input logic [4:0] r);
        clear_in();
        ID_uses_rs1 = 1'b1; ID_rs1_ind = r;
        EX1_memread = 1'b1; EX1_rd_ind = r;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_in();
        EX2_is_jr = 1'b1; EX2_PFC_to_IF = 32'hDEAD_BEEF;
        step(IDLE, "reset_masks_redirect");
        ex1_load_inputs(5'd5);
        step(IDLE, "reset_masks_stall");
        rst = 1'b0;
        clear_in();
        step(IDLE, "reset_idle_run");
        total++;
        if (stall_cycles !== 32'd0 || mispredicts !== 32'd0) begin
            bad++;
            $display("FAIL reset_counters: stall_cycles=%0d mispredicts=%0d required 0/0",
                     stall_cycles, mispredicts);
        end
    endtask

    task automatic test_ex1_load();
        ex1_load_inputs(5'd5);
        step(BUBBLE, "ex1_load_c1");
        clear_in();
        ID_uses_rs1 = 1'b1; ID_rs1_ind = 5'd5; EX2_memread = 1'b1; EX2_rd_ind = 5'd5;
        step(BUBBLE, "ex1_load_c2");
        clear_in();
        step(IDLE, "ex1_load_done");
    endtask

    task automatic test_no_hazard();
        clear_in();
        ID_uses_rs1 = 1'b1; ID_uses_rs2 = 1'b1;
        EX1_memread = 1'b1; EX2_memread = 1'b1;
        step(IDLE, "x0_no_stall");
        clear_in();
        ID_uses_rs1 = 1'b1; ID_rs1_ind = 5'd3; ID_rs2_ind = 5'd9;
        EX1_memread = 1'b1; EX1_rd_ind = 5'd9;
        step(IDLE, "rs2_unused_no_stall");
        EX1_memread = 1'b0; ID_uses_rs2 = 1'b1;
        step(IDLE, "ex1_alu_no_stall");
        EX1_memread = 1'b1;
        step(BUBBLE, "rs2_hazard_c1");
        clear_in();
        step(BUBBLE, "rs2_hazard_c2");
        step(IDLE, "rs2_hazard_done");
    endtask

    task automatic test_ex2_load();
        clear_in();
        ID_uses_rs2 = 1'b1; ID_rs2_ind = 5'd7; EX2_memread = 1'b1; EX2_rd_ind = 5'd7;
        step(BUBBLE, "ex2_load_bubble");
        clear_in();
        step(IDLE, "ex2_load_done");
    endtask

    task automatic test_mispredict();
        clear_in();
        EX2_is_beq = 1'b1; EX2_taken = 1'b1; EX2_PFC_to_IF = 32'h0000_0040;
        step(redir(32'h40), "beq_mispredict");
        step(IDLE, "beq_recover_quiet");
        clear_in();
        step(IDLE, "beq_back_to_run");
        EX2_is_bne = 1'b1; EX2_taken = 1'b1; EX2_predicted = 1'b1; EX2_PFC_to_IF = 32'h80;
        step(IDLE, "bne_correct_target0");
        clear_in();
        EX2_is_beq = 1'b1; EX2_PFC_to_IF = 32'h44;
        step(IDLE, "beq_not_taken_correct");
        clear_in();
        EX2_is_bne = 1'b1; EX2_predicted = 1'b1; EX2_PFC_to_IF = 32'h0000_1234;
        step(redir(32'h1234), "bne_mispredict");
        clear_in();
        step(IDLE, "bne_recover");
    endtask

    task automatic test_priority();
        ex1_load_inputs(5'd12);
        EX2_is_jr = 1'b1; EX2_PFC_to_IF = 32'h200;
        step(redir(32'h200), "mispredict_over_load");
        step(IDLE, "recover_suppresses_hazard");
        clear_in();
        step(IDLE, "priority_done");
    endtask

    task automatic test_stall_mispredict();
        ex1_load_inputs(5'd5);
        step(BUBBLE, "stall_jr_c1");
        clear_in();
        EX2_is_jr = 1'b1; EX2_PFC_to_IF = 32'h100;
        step(redir(32'h100), "stall_jr_redirect");
        step(IDLE, "stall_jr_recover");
        clear_in();
        step(IDLE, "stall_jr_run");
    endtask

    task automatic test_reset_mid_stall();
        ex1_load_inputs(5'd6);
        step(BUBBLE, "rst_stall_c1");
        rst = 1'b1;
        clear_in();
        step(IDLE, "rst_mid_stall");
        rst = 1'b0;
        step(IDLE, "after_rst_run");
        total++;
        if (stall_cycles !== 32'd0 || mispredicts !== 32'd0) begin
            bad++;
            $display("FAIL rst_mid_stall_counters: stall_cycles=%0d mispredicts=%0d required 0/0",
                     stall_cycles, mispredicts);
        end
    endtask

    task automatic test_stats();
        logic [31:0] req_mis, req_st;
        rst = 1'b1;
        clear_in();
        step(IDLE, "stats_reset");
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            clear_in();
            EX2_is_beq = 1'b1; EX2_taken = 1'b1; EX2_PFC_to_IF = 32'h40 + 32'(i) * 32'h10;
            step(redir(32'h40 + 32'(i) * 32'h10), "stats_mispredict");
            clear_in();
            step(IDLE, "stats_recover");
        end
        ex1_load_inputs(5'd5);
        step(BUBBLE, "stats_load_c1");
        clear_in();
        step(BUBBLE, "stats_load_c2");
        step(IDLE, "stats_idle");
        req_mis = STATS ? 32'd3 : 32'd0;
        req_st  = STATS ? 32'd2 : 32'd0;
        total++;
        if (mispredicts !== req_mis) begin
            bad++;
            $display("FAIL stats_mispredicts: got=%0d required=%0d", mispredicts, req_mis);
        end
        total++;
        if (stall_cycles !== req_st) begin
            bad++;
            $display("FAIL stats_stall_cycles: got=%0d required=%0d", stall_cycles, req_st);
        end
    endtask

    // Running model check over the whole run, taken after everything else.
    task automatic test_counter_model();
        logic [31:0] req_mis, req_st;
        req_mis = STATS ? 32'(exp_mis) : 32'd0;
        req_st  = STATS ? 32'(exp_stalls) : 32'd0;
        total++;
        if (mispredicts !== req_mis || stall_cycles !== req_st) begin
            bad++;
            $display("FAIL counter_model: got=%0d/%0d required=%0d/%0d",
                     mispredicts, stall_cycles, req_mis, req_st);
        end
    endtask

    initial begin
        rst = 1'b1;
        clear_in();
        @(posedge clk);
        #1;
        test_reset();
        test_ex1_load();
        test_no_hazard();
        test_ex2_load();
        test_mispredict();
        test_priority();
        test_stall_mispredict();
        test_counter_model();
        test_reset_mid_stall();
        test_stats();
        test_counter_model();
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, as listed in REQ-002 and REQ-003.
REQ-002 clk  in  1  rising-edge clock shared with all pipeline buffers.
REQ-003 rst  in  1  synchronous active-high reset.
REQ-004 ID_rs1_ind, ID_rs2_ind  in  5 each  source register indices of the instruction in ID.
REQ-005 ID_uses_rs1, ID_uses_rs2  in  1 each  ID instruction reads rs1 / rs2.
REQ-006 EX1_rd_ind, EX2_rd_ind  in  5 each  destination indices in EX1 and EX2.
REQ-007 EX1_memread, EX2_memread  in  1 each  load present in EX1 / EX2.
REQ-008 EX2_is_beq, EX2_is_bne, EX2_is_jr  in  1 each  control-flow class of the EX2 instruction.
REQ-009 EX2_taken  in  1  actual branch outcome resolved in EX2.
REQ-010 EX2_predicted  in  1  prediction carried with the EX2 instruction.
REQ-011 EX2_PFC_to_IF  in  32  correct next fetch address for the EX2 instruction.
REQ-012 PC_stall, IFID_stall  out  1 each  hold PC / IF-ID buffer.
REQ-013 IFID_FLUSH, IDEX1_FLUSH, EX1EX2_FLUSH  out  1 each  zero the IF-ID, ID-EX1 and EX1-EX2 buffers on the next edge.
REQ-014 PC_redirect  out  1  load the PC from PC_target.
REQ-015 PC_target  out  32  redirect address.
REQ-016 stall_cycles, mispredicts  out  32 each  statistics counters (see Configuration).

Function
REQ-017 Hazard match SHALL be: source used, source index equal to rd, and rd != 0.
REQ-018 Mispredict SHALL be: (EX2_is_beq|EX2_is_bne) with EX2_taken != EX2_predicted, or EX2_is_jr=1.
REQ-019 The FSM SHALL have the states RUN, STALL and RECOVER.
REQ-020 RUN, mispredict: PC_redirect=1, PC_target=EX2_PFC_to_IF, IFID_FLUSH=IDEX1_FLUSH=EX1EX2_FLUSH=1 in the same cycle; next state RECOVER.
REQ-021 RUN, EX1 load hazard (no mispredict): PC_stall=IFID_stall=IDEX1_FLUSH=1; stall counter loaded with 1; next state STALL.
REQ-022 RUN, EX2 load hazard only: a single-cycle bubble (PC_stall=IFID_stall=IDEX1_FLUSH=1); remain in RUN.
REQ-023 STALL: PC_stall=IFID_stall=IDEX1_FLUSH=1 while the counter is nonzero; the counter decrements each cycle; at zero, the state returns to RUN (two bubble cycles in total for an EX1 load).
REQ-024 Mispredict in STALL SHALL take priority: the counter is cleared, stalls are dropped, the REQ-020 outputs are driven, and the next state is RECOVER.
REQ-025 RECOVER SHALL last exactly one cycle with all outputs inactive and hazard detection suppressed (the pipeline holds only bubbles); next state RUN.
REQ-026 PC_target SHALL be 0 whenever PC_redirect=0.
REQ-027 All control outputs SHALL be combinational from the state and inputs; the state and counters SHALL be registered.

Reset
REQ-028 On rst sampled high, the state SHALL be RUN and the stall counter, stall_cycles and mispredicts SHALL be 0; rst SHALL override every event in the same cycle.
REQ-029 During rst, all flush, stall and redirect outputs SHALL be 0 and PC_target SHALL be 0.

Configuration
REQ-030 With HAZARD_STATS_EN defined, stall_cycles SHALL increment on every cycle with PC_stall=1, and mispredicts SHALL increment on every PC_redirect cycle; both wrap at 2^32.
REQ-031 Without HAZARD_STATS_EN, stall_cycles and mispredicts SHALL be constant 0 and no counter flops SHALL exist.

Verification
REQ-032 Load x5 in EX1, ID reads rs1=x5 -> PC_stall=1 for exactly 2 cycles, IDEX1_FLUSH=1 for both cycles, then RUN.
REQ-033 Load x0 in EX1, ID reads x0 -> no stall.
REQ-034 beq in EX2, predicted=0, taken=1, PFC=0x0000_0040 -> one cycle with PC_redirect=1, PC_target=0x40 and all three flushes=1; the next cycle has all outputs 0.
REQ-035 Mispredict (jr) during the 2nd STALL cycle -> redirect and flush that cycle, PC_stall=0, counter cleared, RECOVER next.
REQ-036 rst asserted mid-STALL -> next cycle is RUN with all outputs 0; with HAZARD_STATS_EN, counters read 0.
REQ-037 HAZARD_STATS_EN build: 3 mispredicts and one EX1 load stall -> mispredicts=3, stall_cycles=2.
